// File: rtl/xpmwrap_sdpram_stream_reader.sv
// Purpose: streams bursts of words from the read port of a 2-cycle-latency simple dual-port RAM onto a valid/ready stream.
// Latency: first beat 3 cycles after the command handshake, then one word per cycle while m_tready is high.
// Backpressure: m_tready low stalls the stream; reads are throttled so buffered plus in-flight words never exceed FIFO_DEPTH.
module xpmwrap_sdpram_stream_reader #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    output logic                  ram_enb,
    output logic                  ram_regceb,
    output logic                  ram_rstb,
    input  logic [DATA_WIDTH-1:0] ram_doutb,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] remaining;

    // Read-tracking pipeline: stage 2 lines up with data on ram_doutb.
    logic p1_vld, p1_last;
    logic p2_vld, p2_last;

    // Output buffer: each entry carries {last, data}.
    logic [DATA_WIDTH:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_count;
    logic [OCC_W-1:0]      occupancy;

    logic accept;
    logic issue;
    logic push;
    logic pop;
    logic credit_ok;
    logic fifo_empty;
    logic fifo_full;
    logic head_last;

    // Words already buffered plus reads still travelling through the RAM.
    assign occupancy  = OCC_W'(fifo_count) + OCC_W'(p1_vld) + OCC_W'(p2_vld);
    assign credit_ok  = occupancy < OCC_W'(FIFO_DEPTH);
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign head_last  = fifo_mem[rd_ptr][DATA_WIDTH];
    assign push       = p2_vld;
    assign pop        = m_tvalid && m_tready;

    // Outputs are forced quiet while rstn is low so nothing stale leaks during reset.
    assign cmd_ready  = rstn && (state == IDLE);
    assign busy       = rstn && (state != IDLE);
    assign ram_enb    = rstn && issue;
    assign ram_addrb  = rstn ? addr : '0;
    assign ram_regceb = 1'b1;
    assign ram_rstb   = ~rstn;
    assign m_tvalid   = rstn && !fifo_empty;
    assign m_tdata    = fifo_mem[rd_ptr][DATA_WIDTH-1:0];
    assign m_tlast    = m_tvalid && head_last;

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, issue reads under credit, wait for the last beat to leave.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (remaining == '0) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && head_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address/count registers and the read-tracking pipeline.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            addr      <= '0;
            remaining <= '0;
            p1_vld    <= 1'b0;
            p1_last   <= 1'b0;
            p2_vld    <= 1'b0;
            p2_last   <= 1'b0;
        end else begin
            if (accept) begin
                addr      <= cmd_addr;
                remaining <= cmd_len;
            end else if (issue) begin
                addr      <= addr + ADDR_WIDTH'(1);
                remaining <= remaining - ADDR_WIDTH'(1);
            end
            p1_vld  <= issue;
            p1_last <= issue && (remaining == '0);
            p2_vld  <= p1_vld;
            p2_last <= p1_last;
        end
    end

    // Buffer storage; contents need no reset because validity lives in the count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {p2_last, ram_doutb};
        end
    end

    // Buffer pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifndef SYNTHESIS
    // A push into a full buffer means the read credit accounting is broken.
    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (!(push && fifo_full)) else $error("stream reader buffer overflow");
        end
    end
`endif

endmodule

// File: tb/tb_xpmwrap_sdpram_stream_reader.sv
// Directed bench for xpmwrap_sdpram_stream_reader with a 2-cycle-latency RAM model preloaded with mem[i]=i.
// Inputs change and outputs are sampled just after the falling edge.
// A closing randomized section checks 1000 bursts against an address-arithmetic reference.
module tb_xpmwrap_sdpram_stream_reader;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_addr;
    logic [5:0]  cmd_len;
    logic [5:0]  ram_addrb;
    logic        ram_enb;
    logic        ram_regceb;
    logic        ram_rstb;
    logic [31:0] ram_doutb;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [64];
    logic [31:0] rd_s1;
    logic [31:0] rd_s2;

    always #5 clk = ~clk;

    xpmwrap_sdpram_stream_reader #(
        .ADDR_WIDTH(6),
        .DATA_WIDTH(32),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .ram_addrb (ram_addrb),
        .ram_enb   (ram_enb),
        .ram_regceb(ram_regceb),
        .ram_rstb  (ram_rstb),
        .ram_doutb (ram_doutb),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .busy      (busy)
    );

    // RAM model: array read register then output register, two cycles total.
    assign ram_doutb = rd_s2;
    always @(posedge clk) begin
        if (ram_enb) rd_s1 <= mem[ram_addrb];
        if (ram_rstb) rd_s2 <= '0;
        else if (ram_regceb) rd_s2 <= rd_s1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] q[$];
        int issued, popped, max_out, acc, stale, got;
        logic [5:0]  ra, rl;
        logic        prev_stall;
        logic [32:0] prev_beat;
        logic [5:0]  ea;

        for (int i = 0; i < 64; i++) mem[i] = 32'(i);
        rstn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; m_tready = 1'b0;

        // ---- reset values ----
        @(negedge clk); #1;
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_enb", ram_enb, 0);
        chk("rst_addrb", ram_addrb, 0);
        chk("rst_rstb", ram_rstb, 1);
        chk("rst_regceb", ram_regceb, 1);
        @(negedge clk); rstn = 1'b1; #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_tvalid", m_tvalid, 0);
        chk("post_rst_tlast", m_tlast, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_enb", ram_enb, 0);
        chk("post_rst_addrb", ram_addrb, 0);
        chk("post_rst_rstb", ram_rstb, 0);

        // ---- basic burst addr=5 len=3 ----
        @(negedge clk); cmd_valid = 1'b1; cmd_addr = 6'd5; cmd_len = 6'd3; m_tready = 1'b1; #1;
        chk("t1_cmd_ready", cmd_ready, 1);
        @(negedge clk); cmd_valid = 1'b0; #1;
        chk("t1_busy", busy, 1);
        chk("t1_cmd_ready_low", cmd_ready, 0);
        chk("t1_enb", ram_enb, 1);
        chk("t1_addrb", ram_addrb, 5);
        @(negedge clk); #1; chk("t1_no_valid_k2", m_tvalid, 0);
        @(negedge clk); #1; chk("t1_no_valid_k3", m_tvalid, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("t1_valid", m_tvalid, 1);
            chk("t1_data", m_tdata, 64'(5 + i));
            chk("t1_last", m_tlast, 64'(i == 3));
        end
        @(negedge clk); #1;
        chk("t1_end_valid", m_tvalid, 0);
        chk("t1_end_ready", cmd_ready, 1);
        chk("t1_end_busy", busy, 0);

        // ---- address wrap addr=62 len=3 ----
        cmd_valid = 1'b1; cmd_addr = 6'd62; cmd_len = 6'd3;
        for (int k = 1; k <= 8; k++) begin
            logic [31:0] wseq [4];
            wseq = '{32'd62, 32'd63, 32'd0, 32'd1};
            @(negedge clk); cmd_valid = 1'b0; #1;
            if (k <= 4) begin
                chk("t2_enb", ram_enb, 1);
                chk("t2_addrb", ram_addrb, 64'(wseq[k-1]));
            end else begin
                chk("t2_enb_off", ram_enb, 0);
            end
            if (k >= 4 && k <= 7) begin
                chk("t2_valid", m_tvalid, 1);
                chk("t2_data", m_tdata, 64'(wseq[k-4]));
                chk("t2_last", m_tlast, 64'(k == 7));
            end else if (k == 8) begin
                chk("t2_end_valid", m_tvalid, 0);
            end
        end

        // ---- backpressure addr=20 len=7, m_tready low for cycles 4..12 ----
        cmd_valid = 1'b1; cmd_addr = 6'd20; cmd_len = 6'd7;
        q.delete(); issued = 0; popped = 0; max_out = 0;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk); cmd_valid = 1'b0; m_tready = !(k >= 4 && k <= 12); #1;
            if (ram_enb) issued++;
            if (issued - popped > max_out) max_out = issued - popped;
            if (k == 5)  chk("t3_enb_credit_out", ram_enb, 0);
            if (k == 12) begin
                chk("t3_stall_valid", m_tvalid, 1);
                chk("t3_stall_data", m_tdata, 20);
            end
            if (k == 13) chk("t3_enb_still_off", ram_enb, 0);
            if (k == 14) chk("t3_enb_resume", ram_enb, 1);
            if (k == 21) chk("t3_done_ready", cmd_ready, 1);
            if (m_tvalid && m_tready) begin
                q.push_back({m_tlast, m_tdata});
                popped++;
            end
        end
        chk("t3_max_buffered", max_out, 4);
        chk("t3_issued", issued, 8);
        chk("t3_beats", q.size(), 8);
        for (int i = 0; i < q.size(); i++) chk("t3_beat", q[i], {(i == 7), 32'(20 + i)});

        // ---- single word addr=9 len=0 ----
        m_tready = 1'b1; cmd_valid = 1'b1; cmd_addr = 6'd9; cmd_len = 6'd0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk); cmd_valid = 1'b0; #1;
            if (k == 1) begin
                chk("t4_enb", ram_enb, 1);
                chk("t4_addrb", ram_addrb, 9);
            end
            if (k == 4) begin
                chk("t4_valid", m_tvalid, 1);
                chk("t4_data", m_tdata, 9);
                chk("t4_last", m_tlast, 1);
                chk("t4_ready_during_beat", cmd_ready, 0);
            end
            if (k == 5) begin
                chk("t4_ready_after", cmd_ready, 1);
                chk("t4_valid_after", m_tvalid, 0);
            end
        end

        // ---- reset mid-burst addr=30 len=7, reset during third beat ----
        cmd_valid = 1'b1; cmd_addr = 6'd30; cmd_len = 6'd7;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk); cmd_valid = 1'b0; #1;
        end
        chk("t5_third_valid", m_tvalid, 1);
        chk("t5_third_data", m_tdata, 32);
        rstn = 1'b0; #1;
        chk("t5_in_reset_valid", m_tvalid, 0);
        @(negedge clk); rstn = 1'b1; #1;
        chk("t5_after_valid", m_tvalid, 0);
        chk("t5_after_busy", busy, 0);
        chk("t5_after_ready", cmd_ready, 1);
        chk("t5_after_enb", ram_enb, 0);
        stale = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            if (m_tvalid) stale++;
        end
        chk("t5_no_stale", stale, 0);
        cmd_valid = 1'b1; cmd_addr = 6'd0; cmd_len = 6'd1;
        q.delete();
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk); cmd_valid = 1'b0; #1;
            if (m_tvalid && m_tready) q.push_back({m_tlast, m_tdata});
        end
        chk("t5_new_beats", q.size(), 2);
        if (q.size() == 2) begin
            chk("t5_beat0", q[0], {1'b0, 32'd0});
            chk("t5_beat1", q[1], {1'b1, 32'd1});
        end

        // ---- cmd_valid held high during a burst: addr=40 len=2 ----
        cmd_valid = 1'b1; cmd_addr = 6'd40; cmd_len = 6'd2;
        acc = 0; q.delete();
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) begin
                @(negedge clk); #1;
            end
            if (cmd_valid && cmd_ready) acc++;
            if (m_tvalid && m_tready) q.push_back({m_tlast, m_tdata});
        end
        chk("t6_one_accept", acc, 1);
        @(negedge clk); #1;
        chk("t6_ready_again", cmd_ready, 1);
        cmd_valid = 1'b0;
        chk("t6_beats", q.size(), 3);
        for (int i = 0; i < q.size(); i++) chk("t6_beat", q[i], {(i == 2), 32'(40 + i)});

        // ---- 1000 random bursts with random m_tready ----
        for (int b = 0; b < 1000; b++) begin
            ra = 6'($urandom_range(0, 63));
            rl = 6'($urandom_range(0, 7));
            for (int n = 0; n < 50 && !cmd_ready; n++) begin
                @(negedge clk); #1;
            end
            cmd_valid = 1'b1; cmd_addr = ra; cmd_len = rl;
            got = 0; prev_stall = 1'b0; prev_beat = '0;
            for (int n = 0; n < 200 && got <= int'(rl); n++) begin
                @(negedge clk); cmd_valid = 1'b0; m_tready = 1'($urandom_range(0, 1)); #1;
                if (m_tvalid && prev_stall) chk("t7_stable", {m_tlast, m_tdata}, prev_beat);
                if (m_tvalid && m_tready) begin
                    ea = ra + 6'(got);
                    chk("t7_beat", {m_tlast, m_tdata}, {(got == int'(rl)), 26'd0, ea});
                    got++;
                end
                prev_stall = m_tvalid && !m_tready;
                prev_beat  = {m_tlast, m_tdata};
            end
            chk("t7_burst_len", got, 64'(int'(rl) + 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xpmwrap_sdpram_stream_reader.md
XPMWRAP_SDPRAM_STREAM_READER -- requirements
Module: xpmwrap_sdpram_stream_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default 6: RAM address width and burst length field width.
REQ-002 Parameter DATA_WIDTH, default 32: RAM word and stream data width.
REQ-003 Parameter FIFO_DEPTH, default 4: output buffer depth in words; legal values are powers of two of at least 4.
REQ-004 The block SHALL use one clock and a synchronous, active-low reset: clk and rstn.
REQ-005 Ports, in order (name, direction, width, meaning):
- clk, in, 1: sole clock; also clocks the RAM (common_clock).
- rstn, in, 1: synchronous active-low reset.
- cmd_valid, in, 1: burst request valid.
- cmd_ready, out, 1: block accepts a burst.
- cmd_addr, in, ADDR_WIDTH: burst start address.
- cmd_len, in, ADDR_WIDTH: words minus 1; a value of 0 means 1 word.
- ram_addrb, out, ADDR_WIDTH: RAM port B read address.
- ram_enb, out, 1: RAM port B enable.
- ram_regceb, out, 1: RAM output register clock enable.
- ram_rstb, out, 1: RAM output register reset, active-high.
- ram_doutb, in, DATA_WIDTH: RAM read data.
- m_tdata, out, DATA_WIDTH: stream data.
- m_tvalid, out, 1: stream data valid.
- m_tready, in, 1: stream data accepted.
- m_tlast, out, 1: final word of the burst.
- busy, out, 1: a burst is in progress.

Function
REQ-006 The attached RAM SHALL have a fixed port-B read latency of 2 cycles: a read issued at edge N presents data on ram_doutb after edge N+2.
REQ-007 ram_regceb SHALL be tied to 1.
REQ-008 ram_rstb SHALL equal the inverse of rstn.
REQ-009 The FSM SHALL have three states: IDLE, ISSUE and DRAIN.
REQ-010 cmd_ready SHALL be high only in IDLE.
REQ-011 A command SHALL be accepted when cmd_valid and cmd_ready are both high; acceptance latches the address and the remaining count (cmd_len) and moves the FSM to ISSUE.
REQ-012 In ISSUE, ram_enb SHALL be asserted with ram_addrb set to the current address only while (fifo_count + inflight) < FIFO_DEPTH.
- inflight: the number of reads issued whose data is not yet written to the FIFO (0 to 2).
REQ-013 On each issued read:
- the address SHALL increment modulo 2^ADDR_WIDTH (an address of 2^ADDR_WIDTH-1 wraps to 0);
- the remaining count SHALL decrement.
REQ-014 The read issued when the remaining count is 0 SHALL be tagged last, and the FSM SHALL move to DRAIN.
REQ-015 A 2-stage valid/last shift pipeline SHALL track reads in flight.
- Stage-2 valid SHALL write ram_doutb and the last tag into the FIFO in the same cycle the data appears.
REQ-016 The FIFO SHALL never overflow; REQ-012 guarantees this.
- A write into a full FIFO SHALL be flagged by a simulation-only assertion.
REQ-017 m_tvalid SHALL equal FIFO not-empty.
- m_tdata and m_tlast SHALL come from the FIFO head.
- The head SHALL be popped when m_tvalid and m_tready are both high.
REQ-018 A simultaneous FIFO push and pop SHALL leave fifo_count unchanged.
REQ-019 m_tdata and m_tlast SHALL stay stable while m_tvalid is high and m_tready is low.
REQ-020 In DRAIN, the FSM SHALL return to IDLE in the cycle after the handshake of the word tagged last.
- cmd_ready SHALL be high in the next cycle.
REQ-021 busy SHALL be high in ISSUE and DRAIN.
REQ-022 With m_tready held high, a burst of L+1 words SHALL sustain 1 word per cycle.
- The first m_tvalid SHALL appear 3 cycles after the cmd handshake edge: 1 cycle to issue, 2 cycles of RAM latency.
REQ-023 A cmd_valid pulse outside IDLE SHALL be ignored and SHALL NOT be queued.

Reset
REQ-024 While rstn is low at a clk edge, the block SHALL reset:
- FSM to IDLE;
- FIFO pointers and count to 0;
- pipeline valids to 0;
- address and count registers to 0.
REQ-025 Output values during reset and on the first cycle after reset:
- Held at 0: m_tvalid, m_tlast, ram_enb, busy, ram_addrb.
- cmd_ready: 0 while rstn is low, 1 from the first cycle after rstn is high.
REQ-026 A reset during ISSUE or DRAIN SHALL abort the burst.
- No partially fetched word SHALL be presented after reset.
- Data returning from reads in flight SHALL be discarded.

Verification
REQ-027 RAM preloaded with mem[i]=i; cmd addr=5, len=3; m_tready=1 -> m_tdata 5,6,7,8 on consecutive cycles; m_tlast with 8 only; first m_tvalid 3 cycles after the cmd handshake.
REQ-028 Wrap: cmd addr=62, len=3 -> ram_addrb sequence 62,63,0,1; m_tdata 62,63,0,1.
REQ-029 Backpressure: len=7 with m_tready low for cycles 4 to 12 -> at most 4 words buffered; ram_enb deasserts when the credit is exhausted; all 8 words arrive in order with no loss or duplication.
REQ-030 Single word: len=0, addr=9 -> one beat, m_tdata=9, m_tlast=1; cmd_ready high again 1 cycle after the beat.
REQ-031 Reset mid-burst: rstn low for 1 cycle during the third beat of len=7 -> m_tvalid=0 and busy=0 the next cycle; no stale data; a new cmd addr=0, len=1 returns exactly 0,1.
REQ-032 cmd_valid held high during a burst -> exactly one burst per IDLE acceptance; random m_tready over 1000 bursts matches a reference-model scoreboard.
